// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle instruction control FSM
module multicycle_control (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    output logic        PC_Sel,
    output logic        PC_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic [1:0]  Imm_Sel,
    output logic        MEM_WrEn,
    output logic        Halted
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [2:0] {CL_ALUR, CL_ALUI, CL_BR, CL_LD, CL_ST, CL_ILL} cls_t;

    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;

    state_t      state, state_next;
    logic [5:0]  opcode_q;
    logic [5:0]  func_q;
    cls_t        cls_live, cls_q;
    logic        unused_bits;

    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            6'b100000:                                    return CL_ALUR;
            OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI:      return CL_ALUI;
            OP_B, OP_BEQ, OP_BNE:                         return CL_BR;
            6'b001111:                                    return CL_LD;
            6'b011111:                                    return CL_ST;
            default:                                      return CL_ILL;
        endcase
    endfunction

    assign cls_live    = classify(Instr[31:26]);
    assign cls_q       = classify(opcode_q);
    assign unused_bits = ^{Instr[25:6], func_q[5:4]};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= FETCH;
            opcode_q <= 6'd0;
            func_q   <= 6'd0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                opcode_q <= Instr[31:26];
                func_q   <= Instr[5:0];
            end
        end
    end

    // Only the classification of the live word steers DECODE; outputs use the latched copy.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: state_next = (cls_live == CL_ILL) ? HALT : EXEC;
            EXEC: begin
                if (cls_q == CL_BR)
                    state_next = FETCH;
                else if (cls_q == CL_ALUR || cls_q == CL_ALUI)
                    state_next = WB;
                else
                    state_next = MEM;
            end
            MEM:    state_next = (cls_q == CL_LD) ? WB : FETCH;
            WB:     state_next = FETCH;
            HALT:   state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        PC_Sel        = 1'b0;
        PC_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = 4'b0000;
        Imm_Sel       = 2'b00;
        MEM_WrEn      = 1'b0;
        Halted        = 1'b0;

        // Datapath selects are driven once the opcode has been latched.
        if (state == EXEC || state == MEM || state == WB) begin
            ALU_Bin_sel = (cls_q == CL_ALUI) || (cls_q == CL_LD) || (cls_q == CL_ST);
            RF_B_sel    = (cls_q == CL_BR) || (cls_q == CL_ST);
            case (cls_q)
                CL_ALUR: ALU_func = func_q[3:0];
                CL_ALUI: begin
                    if (opcode_q == OP_ANDI)
                        ALU_func = 4'b0010;
                    else if (opcode_q == OP_ORI)
                        ALU_func = 4'b0011;
                end
                CL_BR:   ALU_func = (opcode_q == OP_B) ? 4'b0000 : 4'b0001;
                default: ALU_func = 4'b0000;
            endcase
            if (opcode_q == OP_LUI)
                Imm_Sel = 2'b10;
            else if (opcode_q == OP_ANDI || opcode_q == OP_ORI)
                Imm_Sel = 2'b01;
        end

        case (state)
            EXEC: begin
                if (cls_q == CL_BR) begin
                    PC_LdEn = 1'b1;
                    PC_Sel  = (opcode_q == OP_B) ||
                              (opcode_q == OP_BEQ && Zero) ||
                              (opcode_q == OP_BNE && !Zero);
                end
            end
            MEM: begin
                if (cls_q == CL_ST) begin
                    MEM_WrEn = 1'b1;
                    PC_LdEn  = 1'b1;
                end
            end
            WB: begin
                RF_WrEn       = 1'b1;
                RF_WrData_sel = (cls_q == CL_LD);
                PC_LdEn       = 1'b1;
            end
            HALT:    Halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table and scoreboard bench for multicycle_control
module tb_multicycle_control;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic [1:0]  Imm_Sel;
    logic        MEM_WrEn, Halted;

    multicycle_control dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
        .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .RF_WrEn(RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel),
        .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func), .Imm_Sel(Imm_Sel),
        .MEM_WrEn(MEM_WrEn), .Halted(Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zero;
        int          n;
        logic [3:0]  func;
        logic        bin;
        logic [1:0]  imm;
        logic        bsel;
        logic        pcsel;
        logic        rf_wr;
        logic        wrsel;
        logic        mem_wr;
    } vec_t;

    // {PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, ALU_func, Imm_Sel, MEM_WrEn, Halted}
    logic [13:0] exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [13:0] actual();
        return {PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
                ALU_func, Imm_Sel, MEM_WrEn, Halted};
    endfunction

    task automatic push(input logic [13:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        logic [13:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        if (actual() !== e) begin
            bad++;
            $display("FAIL %s got=%b required=%b", t, actual(), e);
        end
    endtask

    task automatic step(input logic [13:0] e, input string tag);
        push(e, tag);
        #1;
        check_pop();
        @(negedge Clk);
    endtask

    task automatic run_vec(input vec_t v);
        logic [13:0] e;
        for (int c = 1; c <= v.n; c++) begin
            e = '0;
            if (c >= 3) begin
                e[9]   = v.bsel;
                e[8]   = v.bin;
                e[7:4] = v.func;
                e[3:2] = v.imm;
            end
            if (c == v.n) e[12] = 1'b1;
            if (c == 3 && v.n == 3) e[13] = v.pcsel;
            if (c == v.n && v.rf_wr) begin
                e[11] = 1'b1;
                e[10] = v.wrsel;
            end
            if (c == 4 && v.mem_wr) e[1] = 1'b1;
            Instr = (c <= 2) ? v.instr : $urandom;
            Zero  = (c == 3) ? v.zero : ~v.zero;
            step(e, $sformatf("%s cyc%0d", v.name, c));
        end
    endtask

    task automatic pulse_reset(input string tag);
        Reset = 1'b0;
        push(14'd0, tag);
        #1;
        check_pop();
        #1;
        Reset = 1'b1;
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        //          name        instr         z  n  func    b  imm    bs pc wr ws mw
        vecs.push_back('{"addi",   32'hC0000005, 0, 4, 4'b0000, 1, 2'b00, 0, 0, 1, 0, 0});
        vecs.push_back('{"alur",   32'h80000026, 0, 4, 4'b0110, 0, 2'b00, 0, 0, 1, 0, 0});
        vecs.push_back('{"li",     32'hE0000000, 1, 4, 4'b0000, 1, 2'b00, 0, 0, 1, 0, 0});
        vecs.push_back('{"lui",    32'hE4000000, 0, 4, 4'b0000, 1, 2'b10, 0, 0, 1, 0, 0});
        vecs.push_back('{"andi",   32'hC8000000, 0, 4, 4'b0010, 1, 2'b01, 0, 0, 1, 0, 0});
        vecs.push_back('{"ori",    32'hCC000000, 1, 4, 4'b0011, 1, 2'b01, 0, 0, 1, 0, 0});
        vecs.push_back('{"lw",     32'h3C000000, 0, 5, 4'b0000, 1, 2'b00, 0, 0, 1, 1, 0});
        vecs.push_back('{"sw",     32'h7C000000, 0, 4, 4'b0000, 1, 2'b00, 1, 0, 0, 0, 1});
        vecs.push_back('{"b",      32'hFC000000, 0, 3, 4'b0000, 0, 2'b00, 1, 1, 0, 0, 0});
        vecs.push_back('{"beq_z1", 32'h00000000, 1, 3, 4'b0001, 0, 2'b00, 1, 1, 0, 0, 0});
        vecs.push_back('{"beq_z0", 32'h00000000, 0, 3, 4'b0001, 0, 2'b00, 1, 0, 0, 0, 0});
        vecs.push_back('{"bne_z0", 32'h04000000, 0, 3, 4'b0001, 0, 2'b00, 1, 1, 0, 0, 0});
        vecs.push_back('{"bne_z1", 32'h04000000, 1, 3, 4'b0001, 0, 2'b00, 1, 0, 0, 0, 0});
        vecs.push_back('{"alur_f", 32'h8000003F, 1, 4, 4'b1111, 0, 2'b00, 0, 0, 1, 0, 0});

        Reset = 1'b0;
        Instr = 32'h0;
        Zero  = 1'b0;
        #3;
        push(14'd0, "reset_outputs");
        check_pop();
        @(negedge Clk);
        #2 Reset = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Illegal opcode halts and stays halted until reset.
        Instr = 32'h54000000;
        Zero  = 1'b0;
        step(14'd0, "halt fetch");
        step(14'd0, "halt decode");
        for (int k = 0; k < 20; k++) begin
            Instr = $urandom;
            Zero  = k[0];
            step(14'd1, $sformatf("halt hold%0d", k));
        end
        pulse_reset("halt reset_async");
        run_vec(vecs[0]);

        // Reset asserted during sw MEM drops MEM_WrEn at once.
        Instr = 32'h7C000000;
        Zero  = 1'b0;
        step(14'd0, "swabort fetch");
        step(14'd0, "swabort decode");
        step(14'b0_0_0_0_1_1_0000_00_0_0, "swabort exec");
        push(14'b0_1_0_0_1_1_0000_00_1_0, "swabort mem");
        #1;
        check_pop();
        pulse_reset("swabort reset_async");
        run_vec(vecs[1]);

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
